// File: rtl/mul_sequencer_if.sv
// Handshake and multiplier-side bus for mul_sequencer.
// slave  : the sequencer itself
// master : the execute stage plus the SB_MAC16 that feeds mul_p back
interface mul_sequencer_if;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;
    logic [31:0] result;
    logic        done;

    modport slave (
        input  start, kill, op, rs1, rs2, mul_p,
        output ready, mul_a, mul_b, result, done
    );

    modport master (
        output start, kill, op, rs1, rs2, mul_p,
        input  ready, mul_a, mul_b, result, done
    );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle RV32M MUL/MULH/MULHSU/MULHU controller driving a
// single 16x16 unsigned multiplier. Magnitudes are multiplied as four partial
// products, accumulated in 64 bits, then sign-corrected.
// Optional feature macro: MUL_ZERO_BYPASS_EN (finish at T1 when an operand is 0).
module mul_sequencer #(
    parameter int MUL_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    mul_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SIGN  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    state_t                  state_r, state_next_s;
    logic                    ready_r, done_r;
    logic [31:0]             result_r;
    logic [15:0]             mul_a_r, mul_b_r;
    logic [15:0]             mul_a_next_s, mul_b_next_s;
    logic [31:0]             abs_a_r, abs_b_r;
    logic                    neg_r;
    logic [1:0]              op_r;
    logic [63:0]             acc_r;
    logic [1:0]              issue_cnt_r, ret_cnt_r;
    logic [MUL_LATENCY-1:0]  pipe_r, pipe_next_s;

    logic                    a_signed_s, b_signed_s;
    logic [31:0]             abs_a_s, abs_b_s;
    logic                    accept_s, zero_s, ret_valid_s;
    logic [1:0]              idx_s;
    logic [31:0]             src_a_s, src_b_s;
    logic [63:0]             addend_s, corr_s;

    assign bus.ready  = ready_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.mul_a  = mul_a_r;
    assign bus.mul_b  = mul_b_r;

    // Operand decode, return-path alignment and sign correction.
    always_comb begin
        a_signed_s  = (bus.op == 2'b01) || (bus.op == 2'b10);
        b_signed_s  = (bus.op == 2'b01);
        abs_a_s     = abs32(bus.rs1, a_signed_s);
        abs_b_s     = abs32(bus.rs2, b_signed_s);
        accept_s    = bus.start && ready_r && !bus.kill;
        zero_s      = (abs_a_s == 32'd0) || (abs_b_s == 32'd0);
        ret_valid_s = pipe_r[MUL_LATENCY-1];
        // Each issue cycle enters the delay line; its tail marks a valid mul_p.
        pipe_next_s = MUL_LATENCY'({pipe_r, (state_r == ST_ISSUE)});
        corr_s      = neg_r ? (~acc_r + 64'd1) : acc_r;
        addend_s    = 64'd0;
        case (ret_cnt_r)
            2'd0:       addend_s = {32'd0, bus.mul_p};
            2'd1, 2'd2: addend_s = {16'd0, bus.mul_p, 16'd0};
            2'd3:       addend_s = {bus.mul_p, 32'd0};
            default:    addend_s = 64'd0;
        endcase
    end

    // Next-state logic and next multiplier operand halves.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef MUL_ZERO_BYPASS_EN
                    state_next_s = zero_s ? ST_DONE : ST_ISSUE;
`else
                    state_next_s = ST_ISSUE;
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = (issue_cnt_r == 2'd3) ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_next_s = (ret_valid_s && (ret_cnt_r == 2'd3)) ? ST_SIGN : ST_DRAIN;
            ST_SIGN:  state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
        if (bus.kill) begin
            state_next_s = ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end

        // Partial-product index: bit1 selects A half, bit0 selects B half.
        idx_s   = (state_r == ST_IDLE) ? 2'd0 : (issue_cnt_r + 2'd1);
        src_a_s = (state_r == ST_IDLE) ? abs_a_s : abs_a_r;
        src_b_s = (state_r == ST_IDLE) ? abs_b_s : abs_b_r;
        mul_a_next_s = 16'd0;
        mul_b_next_s = 16'd0;
        if (state_next_s == ST_ISSUE) begin
            mul_a_next_s = idx_s[1] ? src_a_s[31:16] : src_a_s[15:0];
            mul_b_next_s = idx_s[0] ? src_b_s[31:16] : src_b_s[15:0];
        end else begin
            mul_a_next_s = 16'd0;
            mul_b_next_s = 16'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered outputs, operand latches, counters and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            result_r    <= 32'd0;
            mul_a_r     <= 16'd0;
            mul_b_r     <= 16'd0;
            abs_a_r     <= 32'd0;
            abs_b_r     <= 32'd0;
            neg_r       <= 1'b0;
            op_r        <= 2'b00;
            acc_r       <= 64'd0;
            issue_cnt_r <= 2'd0;
            ret_cnt_r   <= 2'd0;
            pipe_r      <= '0;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
            mul_a_r <= mul_a_next_s;
            mul_b_r <= mul_b_next_s;
            if (bus.kill || (state_r == ST_IDLE)) begin
                pipe_r <= '0;
            end else begin
                pipe_r <= pipe_next_s;
            end

            if (accept_s) begin
                abs_a_r     <= abs_a_s;
                abs_b_r     <= abs_b_s;
                neg_r       <= (a_signed_s & bus.rs1[31]) ^ (b_signed_s & bus.rs2[31]);
                op_r        <= bus.op;
                acc_r       <= 64'd0;
                issue_cnt_r <= 2'd0;
                ret_cnt_r   <= 2'd0;
`ifdef MUL_ZERO_BYPASS_EN
                if (zero_s) begin
                    result_r <= 32'd0;
                end
`endif
            end else if (bus.kill) begin
                issue_cnt_r <= 2'd0;
                ret_cnt_r   <= 2'd0;
            end else begin
                if (state_r == ST_ISSUE) begin
                    issue_cnt_r <= issue_cnt_r + 2'd1;
                end
                if (ret_valid_s) begin
                    acc_r     <= acc_r + addend_s;
                    ret_cnt_r <= ret_cnt_r + 2'd1;
                end
                if (state_r == ST_SIGN) begin
                    acc_r    <= corr_s;
                    result_r <= (op_r == 2'b00) ? corr_s[31:0] : corr_s[63:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed cases plus randomized ops
// against a plain-arithmetic reference; includes a latency-accurate model of
// the 16x16 multiplier. Override LAT to exercise other multiplier latencies.
module tb_mul_sequencer;
    parameter int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mul_sequencer_if bus();

    int n_checks = 0;
    int n_pass   = 0;
    int ops_done = 0;
    int done_cnt = 0;
    logic [31:0] last_result = 32'd0;
    logic [31:0] mpipe [LAT];

    mul_sequencer #(.MUL_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Multiplier model: product of the operands presented LAT cycles earlier.
    always @(posedge clk) begin
        mpipe[0] <= 32'(bus.mul_a) * 32'(bus.mul_b);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_p = mpipe[LAT-1];

    // Count every done pulse seen.
    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: full signed/unsigned 64-bit product, pick requested half.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        sb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = sa * sb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_BYPASS_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return 6 + LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Wait for ready, present one request; returns #1 into T1.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        while (bus.ready !== 1'b1 && k < 64) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 64) check("ready_wait", 64'(bus.ready), 64'd1);
        bus.start = 1'b1; bus.op = o; bus.rs1 = a; bus.rs2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Full operation: latency, result, single done pulse, idle outputs.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        start_op(o, a, b);
        n = 1;
        while (bus.done !== 1'b1 && n < 64) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.op    = 2'($urandom_range(0, 3));
            bus.rs1   = $urandom;
            bus.rs2   = $urandom;
            @(posedge clk); #1; n++;
        end
        bus.start = 1'b0;
        check("latency", 64'(n), 64'(exp_lat(a, b)));
        check("result", 64'(bus.result), 64'(exp));
        ops_done++;
        @(posedge clk); #1;
        check("done_pulse", 64'(bus.done), 64'd0);
        check("ready_back", 64'(bus.ready), 64'd1);
        check("mul_idle", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        last_result = exp;
    endtask

    initial begin
        int snap;
        logic [1:0] o;
        logic [31:0] a, b;
        bus.start = 1'b0; bus.kill = 1'b0; bus.op = 2'b00; bus.rs1 = 32'd0; bus.rs2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_mul", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        rst = 1'b0;

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd2, 32'h8000_0000, 32'h0000_0001);

        // Kill at T3 of a MULHU.
        start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check("kill_ready", 64'(bus.ready), 64'd1);
        check("kill_done", 64'(bus.done), 64'd0);
        check("kill_result", 64'(bus.result), 64'(last_result));
        check("kill_mul", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        snap = done_cnt;
        repeat (12) @(posedge clk);
        #1;
        check("kill_no_done", 64'(done_cnt), 64'(snap));

        // Kill in IDLE blocks a simultaneous start.
        bus.kill = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.rs1 = 32'd9; bus.rs2 = 32'd9;
        @(posedge clk); #1;
        bus.kill = 1'b0; bus.start = 1'b0;
        check("kill_idle_ready", 64'(bus.ready), 64'd1);
        run_op(2'b00, 32'd3, 32'd5, 32'h0000_000F);

        // Asynchronous reset at T2 of a MUL.
        start_op(2'b00, 32'd1234, 32'd5678);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_ready", 64'(bus.ready), 64'd1);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_result", 64'(bus.result), 64'd0);
        check("arst_mul", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        last_result = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero operands.
        run_op(2'b01, 32'd0, 32'h1234_5678, 32'd0);
        run_op(2'b11, 32'hDEAD_BEEF, 32'd0, 32'd0);

        // Randomized operations against the reference.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(o, a, b, ref_mul(o, a, b));
        end

        repeat (2) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt), 64'(ops_done));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for RISC-V M-extension multiplies: MUL, MULH, MULHSU and MULHU.
- Sits directly upstream of the single 16x16 unsigned SB_MAC16 multiplier. It feeds that multiplier 16-bit operand halves and consumes its 32-bit products.
- Accumulates four partial products into a 64-bit sum, applies sign correction, and returns the requested 32-bit half to the execute stage.
- Uses a start/ready/done handshake; the pipeline stalls while the block is busy.

Parameters:
- MUL_LATENCY, 1, cycles from mul_a/mul_b presented to the matching mul_p valid. Legal range 1..3. Default matches a DSP with A_REG=B_REG=1 and no output registers.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when start & ready
- kill  input  1  synchronous abort from pipeline flush
- op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- rs1  input  32  operand A
- rs2  input  32  operand B
- ready  output  1  high in IDLE only
- mul_a  output  16  multiplier operand A half
- mul_b  output  16  multiplier operand B half
- mul_p  input  32  unsigned product returned by the multiplier
- result  output  32  final result; held until the next accept
- done  output  1  one-cycle pulse when result is valid

Behaviour:
- Reset (asynchronous): state=IDLE, ready=1, done=0, result=0, mul_a=0, mul_b=0, accumulator=0, issue and return counters=0.
- Operand signedness:
  - A is signed for MULH and MULHSU.
  - B is signed for MULH only.
- Accept cycle (call it T0):
  - Latch |A| and |B| as 32-bit unsigned values; |0x80000000| = 0x80000000.
  - Latch neg = sign(A) XOR sign(B), each sign taken only if that operand is signed.
  - Latch op; clear the accumulator; go to ISSUE.
- ISSUE state, cycles T1..T4, one partial product per cycle, in this order:
  - pp0 = AL*BL, shift 0
  - pp1 = AL*BH, shift 16
  - pp2 = AH*BL, shift 16
  - pp3 = AH*BH, shift 32
- mul_a and mul_b are 0 in every state other than ISSUE.
- Return path: mul_p for the issue at cycle Tk is sampled at T(k+MUL_LATENCY). It is zero-extended, shifted, and added into the 64-bit accumulator. The add is modulo 2^64 and cannot overflow for unsigned inputs.
- After the fourth return, go to SIGN for one cycle: accumulator = neg ? (~acc + 1) : acc.
- DONE state, one cycle:
  - result = acc[31:0] for MUL, acc[63:32] otherwise.
  - done=1; go to IDLE.
- Total latency: done is asserted at T(6+MUL_LATENCY), i.e. T7 with the default. ready returns high in the cycle after done.
- ready=0 in every non-IDLE state; start is ignored while busy.
- kill:
  - In any non-IDLE state: next state IDLE, no done, result unchanged, mul_a/mul_b driven 0.
  - In IDLE: a simultaneous start is not accepted.
- kill takes priority over the DONE transition; kill during the DONE cycle still lets that cycle's done stand, because done is a registered output already asserted.
- Reset mid-operation: immediate return to the reset values; no done.
- Back-to-back: start may be asserted in the cycle ready returns high. The maximum issue rate is one operation per 7+MUL_LATENCY cycles.
- op and rs1/rs2 are sampled only at accept; later changes have no effect.

Optional Feature:
- Macro MUL_ZERO_BYPASS_EN.
- Defined:
  - If the latched |A|==0 or |B|==0 at accept, ISSUE and SIGN are skipped.
  - done with result=0 is asserted at T1; mul_a/mul_b stay 0.
- Undefined: zero operands take the full sequence; result is still 0.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3) -> done at T7, result=0xFFFFFFEB.
- MULH, rs1=rs2=0x80000000 -> result=0x40000000. MULHU, rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE.
- MULHSU, rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF -> result=0xFFFFFFFF. MULHSU, rs1=2, rs2=0x80000000 -> result=0x00000001.
- kill at T3 of a MULHU -> no done, ready high at T4, result keeps its prior value. A following MUL 3*5 -> result=0x0000000F.
- rst pulse at T2 of a MUL -> all outputs return to reset values asynchronously. start during busy cycles -> ignored, exactly one done.
- MUL_ZERO_BYPASS_EN defined, MULH with rs1=0 -> done at T1, result=0. MUL_ZERO_BYPASS_EN undefined -> done at T7, result=0. Repeat all tests with MUL_LATENCY=3 -> done at T9.
